ddr3_port_arbiter: RTL
======================

// Module: ddr3_port_arbiter
// PURPOSE
// - Shares the single DDR3 controller native port among three burst requesters:
//   HDMI-tx frame reader (0), HDMI-rx frame writer (1) and RISC-V/CPU bridge (2).
// - Sits between the video DMA engines / CPU bridge and the DDR3 MC user interface, in the sys_clk domain.
// - Fixed priority 0>1>2. A starvation guard forces a CPU grant after STARVE_MAX consecutive video grants.
// PARAMETERS
// - ADDR_W      28   byte address width to the MC
// - DATA_W      128  MC user data width
// - LEN_W       8    burst length field; value = beats-1
// - STARVE_MAX  16   video grants tolerated while the CPU waits; must be >= 1
// PORTS
// - sys_clk       in   1          sole clock
// - nrst          in   1          asynchronous, active-low reset
// - req           in   3          per-requester burst request, level
// - req_we        in   3          1 = write burst, 0 = read burst
// - req_addr      in   3*ADDR_W   packed start address; slice i belongs to requester i
// - req_len       in   3*LEN_W    packed beats-1 per requester
// - gnt           out  3          one-hot; high for the whole owned transaction
// - done          out  3          1-cycle pulse when the owned burst completes
// - wdata         in   3*DATA_W   packed write data
// - wvalid        in   3          write beat valid
// - wready        out  3          write beat accepted
// - rdata         out  DATA_W     read data, broadcast to all requesters
// - rvalid        out  3          read beat valid; no backpressure
// - mc_cmd_valid  out  1          command valid to the MC
// - mc_cmd_ready  in   1          MC accepts the command
// - mc_cmd_we     out  1          write/read select to the MC
// - mc_cmd_addr   out  ADDR_W     burst address to the MC
// - mc_cmd_len    out  LEN_W      burst beats-1 to the MC
// - mc_wdata      out  DATA_W     write data to the MC
// - mc_wvalid     out  1          write beat valid to the MC
// - mc_wready     in   1          MC accepts the write beat
// - mc_rdata      in   DATA_W     read data from the MC
// - mc_rvalid     in   1          read beat valid from the MC
// BEHAVIOUR
// - Reset: state IDLE; gnt, done, mc_cmd_valid and starve_cnt are 0; the beat counter and command registers are 0.
// - Reset mid-burst aborts the transaction immediately with no done pulse. The MC is reset from the same nrst.
// - FSM IDLE->CMD->(WDATA|RDATA)->DONE->IDLE.
// - IDLE:
//   - When any req is high, pick sel and register it.
//   - Register we, addr and len from slice sel.
//   - Set gnt[sel]. The next cycle is CMD.
//   - Latency from req to gnt/mc_cmd_valid is exactly 1 cycle.
// - Pick rule: if req[2] is high and starve_cnt>=STARVE_MAX, pick 2. Otherwise pick the lowest-index req.
// - starve_cnt: +1 (saturating) on each grant to 0 or 1 while req[2] is high. Cleared on a grant to 2.
// - CMD:
//   - Hold mc_cmd_valid=1 with stable fields until mc_cmd_ready.
//   - On acceptance, clear beat=0 and go to WDATA if we, else RDATA.
// - WDATA: mc_wdata=wdata[sel], mc_wvalid=wvalid[sel], wready[sel]=mc_wready. wready is 0 for all others.
// - A write beat transfers when mc_wvalid&mc_wready. Increment beat; after beat==len transfers, go to DONE.
// - RDATA: rdata=mc_rdata, rvalid[sel]=mc_rvalid. rvalid is 0 for all others.
// - In RDATA, count mc_rvalid beats; after beat==len, go to DONE.
// - DONE: done[sel]=1 for one cycle; gnt drops on the IDLE entry.
// - A requester must drop req in the cycle done is seen; a req still high in IDLE is re-arbitrated.
// - req is sampled only in IDLE. A deassert mid-burst is ignored and the burst still completes.
// - Requester addr/len/we may change once gnt is seen, because they are latched.
// - Outside WDATA: mc_wvalid=0 and wready=0. Outside RDATA: rvalid=0.
// - len=0 means a single beat. len=2^LEN_W-1 means the maximum burst; the beat counter is LEN_W bits with no wrap.
// - Simultaneous req from all three without starvation: 0 wins.
// STRUCTURE
// - Package ddr3_arb_pkg: state encoding; REQ_VRD=0, REQ_VWR=1, REQ_CPU=2; NREQ=3.
// - Sub-module ddr3_arb_pick: combinational picker plus the starve_cnt register.
// - The FSM, latches and muxes stay in the top module.
// TESTING
// - Single CPU read, len=3, mc_cmd_ready delayed 2 cycles:
//   mc_cmd_valid is held 3 cycles, 4 rvalid[2] pulses follow, then done[2] fires once.
// - req=3'b111 together -> gnt=3'b001 first. After done and req[0] drops -> gnt=3'b010, then 3'b100.
// - STARVE_MAX=4, req[0] held continuously, req[2] high:
//   the 5th grant goes to CPU; starve_cnt clears; requester 0 regains the port next.
// - Write len=7 with mc_wready toggled every cycle:
//   exactly 8 beats reach the MC in order; no wready to others; done[1] is 1 cycle.
// - nrst asserted during WDATA beat 3 -> all outputs 0 the same cycle; no done.
//   After release, a fresh req is granted with 1-cycle latency.
// - len=0 read -> one beat, then DONE. req[1] dropped mid-RDATA -> burst completes anyway.

Source files
------------

// File: rtl/ddr3_arb_pkg.sv
// Shared definitions for the DDR3 native-port arbiter: requester indices,
// FSM state encoding and a one-hot helper.
package ddr3_arb_pkg;

  localparam int NREQ = 3;

  typedef logic [1:0] req_idx_t;

  localparam req_idx_t REQ_VRD = 2'd0;
  localparam req_idx_t REQ_VWR = 2'd1;
  localparam req_idx_t REQ_CPU = 2'd2;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_CMD   = 3'd1;
  localparam logic [2:0] ST_WDATA = 3'd2;
  localparam logic [2:0] ST_RDATA = 3'd3;
  localparam logic [2:0] ST_DONE  = 3'd4;

  function automatic logic [NREQ-1:0] idx_onehot(input req_idx_t idx);
    logic [NREQ-1:0] oh;
    oh = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (idx == req_idx_t'(i)) oh[i] = 1'b1;
    end
    return oh;
  endfunction

endpackage

// File: rtl/ddr3_arb_pick.sv
// Fixed-priority requester picker (0>1>2) with a starvation guard that
// forces a CPU pick once the CPU has waited through STARVE_MAX video grants.
module ddr3_arb_pick
  import ddr3_arb_pkg::*;
#(
  parameter int STARVE_MAX = 16
) (
  input  logic            sys_clk,
  input  logic            nrst,
  input  logic [NREQ-1:0] req,
  input  logic            grant_en,
  output req_idx_t        sel
);

  localparam int CNT_W = $clog2(STARVE_MAX + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_MAX);

  logic [CNT_W-1:0] starve_cnt_reg;
  logic             starved;

  assign starved = req[REQ_CPU] && (starve_cnt_reg >= CNT_MAX);

  always_comb begin
    sel = REQ_CPU;
    if (!starved) begin
      if (req[REQ_VRD])      sel = REQ_VRD;
      else if (req[REQ_VWR]) sel = REQ_VWR;
    end
  end

  // Only video grants made while the CPU is actually waiting count toward starvation.
  always_ff @(posedge sys_clk or negedge nrst) begin
    if (!nrst) begin
      starve_cnt_reg <= '0;
    end else if (grant_en) begin
      if (sel == REQ_CPU) begin
        starve_cnt_reg <= '0;
      end else if (req[REQ_CPU] && (starve_cnt_reg != CNT_MAX)) begin
        starve_cnt_reg <= starve_cnt_reg + 1'b1;
      end
    end
  end

endmodule

// File: rtl/ddr3_port_arbiter.sv
// Shares the DDR3 controller native port among the HDMI-tx reader, HDMI-rx
// writer and CPU bridge; one whole burst per grant.
module ddr3_port_arbiter
  import ddr3_arb_pkg::*;
#(
  parameter int ADDR_W     = 28,
  parameter int DATA_W     = 128,
  parameter int LEN_W      = 8,
  parameter int STARVE_MAX = 16
) (
  input  logic                   sys_clk,
  input  logic                   nrst,
  input  logic [NREQ-1:0]        req,
  input  logic [NREQ-1:0]        req_we,
  input  logic [NREQ*ADDR_W-1:0] req_addr,
  input  logic [NREQ*LEN_W-1:0]  req_len,
  output logic [NREQ-1:0]        gnt,
  output logic [NREQ-1:0]        done,
  input  logic [NREQ*DATA_W-1:0] wdata,
  input  logic [NREQ-1:0]        wvalid,
  output logic [NREQ-1:0]        wready,
  output logic [DATA_W-1:0]      rdata,
  output logic [NREQ-1:0]        rvalid,
  output logic                   mc_cmd_valid,
  input  logic                   mc_cmd_ready,
  output logic                   mc_cmd_we,
  output logic [ADDR_W-1:0]      mc_cmd_addr,
  output logic [LEN_W-1:0]       mc_cmd_len,
  output logic [DATA_W-1:0]      mc_wdata,
  output logic                   mc_wvalid,
  input  logic                   mc_wready,
  input  logic [DATA_W-1:0]      mc_rdata,
  input  logic                   mc_rvalid
);

  logic [2:0]        state_reg, state_next;
  req_idx_t          sel_reg;
  req_idx_t          pick_sel;
  logic              we_reg;
  logic [ADDR_W-1:0] addr_reg;
  logic [LEN_W-1:0]  len_reg;
  logic [LEN_W-1:0]  beat_reg;
  logic              grant_en;
  logic              beat_fire;
  logic              last_beat;

  logic [ADDR_W-1:0] addr_slice  [NREQ];
  logic [LEN_W-1:0]  len_slice   [NREQ];
  logic [DATA_W-1:0] wdata_slice [NREQ];

  genvar gi;
  generate
    for (gi = 0; gi < NREQ; gi++) begin : g_req
      assign addr_slice[gi]  = req_addr[gi*ADDR_W +: ADDR_W];
      assign len_slice[gi]   = req_len[gi*LEN_W +: LEN_W];
      assign wdata_slice[gi] = wdata[gi*DATA_W +: DATA_W];
      assign gnt[gi]    = (state_reg != ST_IDLE) && (sel_reg == req_idx_t'(gi));
      assign done[gi]   = (state_reg == ST_DONE) && (sel_reg == req_idx_t'(gi));
      assign wready[gi] = (state_reg == ST_WDATA) && (sel_reg == req_idx_t'(gi)) && mc_wready;
      assign rvalid[gi] = (state_reg == ST_RDATA) && (sel_reg == req_idx_t'(gi)) && mc_rvalid;
    end
  endgenerate

  assign grant_en = (state_reg == ST_IDLE) && (|req);

  ddr3_arb_pick #(
    .STARVE_MAX(STARVE_MAX)
  ) u_pick (
    .sys_clk (sys_clk),
    .nrst    (nrst),
    .req     (req),
    .grant_en(grant_en),
    .sel     (pick_sel)
  );

  assign mc_cmd_valid = (state_reg == ST_CMD);
  assign mc_cmd_we    = we_reg;
  assign mc_cmd_addr  = addr_reg;
  assign mc_cmd_len   = len_reg;
  assign mc_wvalid    = (state_reg == ST_WDATA) && wvalid[sel_reg];
  assign mc_wdata     = (state_reg == ST_WDATA) ? wdata_slice[sel_reg] : '0;
  assign rdata        = (state_reg == ST_RDATA) ? mc_rdata : '0;

  assign beat_fire = ((state_reg == ST_WDATA) && mc_wvalid && mc_wready) ||
                     ((state_reg == ST_RDATA) && mc_rvalid);
  assign last_beat = (beat_reg == len_reg);

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE:  if (|req) state_next = ST_CMD;
      ST_CMD:   if (mc_cmd_ready) state_next = we_reg ? ST_WDATA : ST_RDATA;
      ST_WDATA: if (beat_fire && last_beat) state_next = ST_DONE;
      ST_RDATA: if (beat_fire && last_beat) state_next = ST_DONE;
      ST_DONE:  state_next = ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
  end

  // Command fields are latched at grant so requesters may move on once gnt is seen.
  always_ff @(posedge sys_clk or negedge nrst) begin
    if (!nrst) begin
      state_reg <= ST_IDLE;
      sel_reg   <= REQ_VRD;
      we_reg    <= 1'b0;
      addr_reg  <= '0;
      len_reg   <= '0;
      beat_reg  <= '0;
    end else begin
      state_reg <= state_next;
      if (grant_en) begin
        sel_reg  <= pick_sel;
        we_reg   <= req_we[pick_sel];
        addr_reg <= addr_slice[pick_sel];
        len_reg  <= len_slice[pick_sel];
      end
      if ((state_reg == ST_CMD) && mc_cmd_ready) begin
        beat_reg <= '0;
      end else if (beat_fire && !last_beat) begin
        beat_reg <= beat_reg + 1'b1;
      end
    end
  end

endmodule
